// File: rtl/bin2bcd_pkg.sv
// Shared constants for the binary-to-BCD display path: FSM encoding, segment codes,
// and the digit-count helper used to reject under-sized D at elaboration.
package bin2bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;

    // Active-low, segment a in bit 6 down to g in bit 0.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;

    function automatic int min_digits(input int w);
        longint maxv;
        longint pw;
        int     d;
        maxv = (longint'(1) << w) - 1;
        d    = 1;
        pw   = 10;
        while (pw <= maxv) begin
            d++;
            pw = pw * 10;
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_display_seg7_digit.sv
// Combinational BCD digit to active-low seven-segment decoder with blank override.
// Zero latency; no flow control. Non-decimal codes decode to blank.
module seg7_digit
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bin2bcd_display.sv
// Sequential double-dabble converter driving D seven-segment digits; W+1 clocks from the
// accepting edge to the Done cycle. Start is only sampled while idle; requests while busy are dropped.
module bin2bcd_display
    import bin2bcd_pkg::*;
#(
    parameter int W        = 8,
    parameter int D        = 3,
    parameter int BLANK_LZ = 1
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic           Start,
    input  logic [W-1:0]   Bin,
    output logic           Busy,
    output logic           Done,
    output logic [4*D-1:0] Bcd,
    output logic [7*D-1:0] HEX
);

    localparam int TW = 4 * D;
    localparam int NW = $clog2(W + 1);

    if (W < 1 || W > 32) begin : g_bad_w
        $error("bin2bcd_display: W must be in 1..32");
    end
    if (D < min_digits(W)) begin : g_bad_d
        $error("bin2bcd_display: D too small for W");
    end

    logic [1:0]     state_q, state_d;
    logic [W-1:0]   s_q, s_d;
    logic [TW-1:0]  t_q, t_d;
    logic [NW-1:0]  n_q, n_d;
    logic           done_q, done_d;
    logic [TW-1:0]  bcd_q, bcd_d;
    logic [7*D-1:0] hex_q, hex_d;

    logic [TW-1:0]   t_adj;
    logic [TW+W-1:0] ts;
    logic [D-1:0]    blank;
    logic            zeros_above;
    logic [7*D-1:0]  hex_dec;

    // A digit is blanked only if it and every more-significant digit are zero.
    always_comb begin
        blank       = '0;
        zeros_above = 1'b1;
        for (int i = D - 1; i >= 0; i--) begin
            zeros_above = zeros_above && (t_q[4*i +: 4] == 4'd0);
            blank[i]    = (BLANK_LZ != 0) && (i != 0) && zeros_above;
        end
    end

    for (genvar g = 0; g < D; g++) begin : g_dig
        seg7_digit u_seg (
            .digit_i (t_q[4*g +: 4]),
            .blank_i (blank[g]),
            .seg_o   (hex_dec[7*g +: 7])
        );
    end

    always_comb begin
        t_adj = '0;
        for (int i = 0; i < D; i++) begin
            t_adj[4*i +: 4] = (t_q[4*i +: 4] >= 4'd5) ? t_q[4*i +: 4] + 4'd3 : t_q[4*i +: 4];
        end
        ts = {t_adj, s_q} << 1;

        state_d = state_q;
        s_d     = s_q;
        t_d     = t_q;
        n_d     = n_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        hex_d   = hex_q;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    s_d     = Bin;
                    t_d     = '0;
                    n_d     = NW'(W);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                t_d = ts[TW+W-1:W];
                s_d = ts[W-1:0];
                n_d = n_q - NW'(1);
                if (n_q == NW'(1)) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                bcd_d   = t_q;
                hex_d   = hex_dec;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            t_q     <= '0;
            n_q     <= '0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            hex_q   <= '1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            t_q     <= t_d;
            n_q     <= n_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            hex_q   <= hex_d;
        end
    end

    assign Busy = (state_q != ST_IDLE);
    assign Done = done_q;
    assign Bcd  = bcd_q;
    assign HEX  = hex_q;

endmodule

// File: tb/tb_bin2bcd_display.sv
// Scoreboard bench: directed and random conversions on 8-bit/3-digit (blanked and unblanked)
// and 4-bit/2-digit instances, checked against a decimal-arithmetic reference.
module tb_bin2bcd_display;

    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Start8, Start4;
    logic [7:0]  Bin8;
    logic [3:0]  Bin4;
    logic        Busy8, Done8, Busy8n, Done8n, Busy4, Done4;
    logic [11:0] Bcd8, Bcd8n;
    logic [20:0] HEX8, HEX8n;
    logic [7:0]  Bcd4;
    logic [13:0] HEX4;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done8_cnt = 0;
    int q8[$];
    int q8n[$];
    int q4[$];
    logic [6:0] seg_tab [10];

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc++;

    bin2bcd_display #(.W(8), .D(3), .BLANK_LZ(1)) dut8 (
        .Clock(Clock), .Resetn(Resetn), .Start(Start8), .Bin(Bin8),
        .Busy(Busy8), .Done(Done8), .Bcd(Bcd8), .HEX(HEX8));
    bin2bcd_display #(.W(8), .D(3), .BLANK_LZ(0)) dut8n (
        .Clock(Clock), .Resetn(Resetn), .Start(Start8), .Bin(Bin8),
        .Busy(Busy8n), .Done(Done8n), .Bcd(Bcd8n), .HEX(HEX8n));
    bin2bcd_display #(.W(4), .D(2), .BLANK_LZ(1)) dut4 (
        .Clock(Clock), .Resetn(Resetn), .Start(Start4), .Bin(Bin4),
        .Busy(Busy4), .Done(Done4), .Bcd(Bcd4), .HEX(HEX4));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] exp_bcd(input int v, input int d);
        logic [31:0] r = '0;
        int p = v;
        for (int i = 0; i < d; i++) begin
            r = r | (32'(p % 10) << (4 * i));
            p = p / 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_hex(input int v, input int d, input bit blz);
        logic [31:0] r = '0;
        logic [6:0]  code;
        int pw = 1;
        for (int i = 0; i < d; i++) begin
            code = (blz && i > 0 && v < pw) ? 7'h7F : seg_tab[(v / pw) % 10];
            r = r | (32'(code) << (7 * i));
            pw = pw * 10;
        end
        return r;
    endfunction

    always @(negedge Clock) begin
        int v;
        if (Done8) begin
            done8_cnt++;
            check("done8_expected", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) begin
                v = q8.pop_front();
                check("bcd8", 32'(Bcd8), exp_bcd(v, 3));
                check("hex8", 32'(HEX8), exp_hex(v, 3, 1'b1));
            end
        end
        if (Done8n) begin
            check("done8n_expected", 32'(q8n.size() != 0), 32'd1);
            if (q8n.size() != 0) begin
                v = q8n.pop_front();
                check("bcd8n", 32'(Bcd8n), exp_bcd(v, 3));
                check("hex8n", 32'(HEX8n), exp_hex(v, 3, 1'b0));
            end
        end
        if (Done4) begin
            check("done4_expected", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) begin
                v = q4.pop_front();
                check("bcd4", 32'(Bcd4), exp_bcd(v, 2));
                check("hex4", 32'(HEX4), exp_hex(v, 2, 1'b1));
            end
        end
    end

    task automatic wait_done8(output int c);
        for (int k = 0; k < 40; k++) begin
            if (Done8) break;
            @(negedge Clock);
        end
        check("done8_seen", 32'(Done8), 32'd1);
        c = cyc;
    endtask

    task automatic conv8(input int v);
        int busy_n = 0;
        @(negedge Clock);
        Start8 = 1'b1;
        Bin8   = 8'(v);
        q8.push_back(v);
        q8n.push_back(v);
        @(negedge Clock);
        Start8 = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (Done8) break;
            if (Busy8) busy_n++;
            @(negedge Clock);
        end
        check("done8_seen", 32'(Done8), 32'd1);
        check("busy8_cycles", 32'(busy_n), 32'd9);
        check("busy8_in_done", 32'(Busy8), 32'd0);
    endtask

    task automatic conv4(input int v);
        int busy_n = 0;
        @(negedge Clock);
        Start4 = 1'b1;
        Bin4   = 4'(v);
        q4.push_back(v);
        @(negedge Clock);
        Start4 = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (Done4) break;
            if (Busy4) busy_n++;
            @(negedge Clock);
        end
        check("done4_seen", 32'(Done4), 32'd1);
        check("busy4_cycles", 32'(busy_n), 32'd5);
    endtask

    initial begin
        int c1, c2, d0;
        seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
        seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
        seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
        seg_tab[9] = 7'b0000100;
        Resetn = 1'b0;
        Start8 = 1'b0; Start4 = 1'b0;
        Bin8 = '0; Bin4 = '0;
        repeat (3) @(negedge Clock);
        check("rst_busy8", 32'(Busy8), 32'd0);
        check("rst_done8", 32'(Done8), 32'd0);
        check("rst_bcd8", 32'(Bcd8), 32'd0);
        check("rst_hex8", 32'(HEX8), 32'h1FFFFF);
        check("rst_bcd4", 32'(Bcd4), 32'd0);
        check("rst_hex4", 32'(HEX4), 32'h3FFF);
        Resetn = 1'b1;

        conv8(255);
        check("hex8_255_literal", 32'(HEX8), 32'({7'b0010010, 7'b0100100, 7'b0100100}));
        conv8(0);
        check("hex8n_0_literal", 32'(HEX8n), 32'({7'b0000001, 7'b0000001, 7'b0000001}));

        // Back-to-back with Start held high through the first Done cycle.
        @(negedge Clock);
        Start8 = 1'b1;
        Bin8   = 8'd7;
        q8.push_back(7);   q8n.push_back(7);
        q8.push_back(100); q8n.push_back(100);
        @(negedge Clock);
        Bin8 = 8'd100;
        wait_done8(c1);
        @(negedge Clock);
        Start8 = 1'b0;
        wait_done8(c2);
        check("b2b_done_spacing", 32'(c2 - c1), 32'd10);

        // Starts during busy are dropped and Bin is not re-sampled.
        @(negedge Clock);
        Start8 = 1'b1;
        Bin8   = 8'd42;
        q8.push_back(42); q8n.push_back(42);
        @(negedge Clock); Start8 = 1'b0;
        @(negedge Clock);
        @(negedge Clock); Start8 = 1'b1;
        @(negedge Clock); Start8 = 1'b0; Bin8 = 8'd200;
        @(negedge Clock); Start8 = 1'b1;
        @(negedge Clock); Start8 = 1'b0;
        d0 = done8_cnt;
        repeat (30) @(negedge Clock);
        check("ignored_start_one_done", 32'(done8_cnt - d0), 32'd1);

        // Reset in mid-conversion aborts without a Done.
        @(negedge Clock);
        Start8 = 1'b1;
        Bin8   = 8'd199;
        @(negedge Clock); Start8 = 1'b0;
        repeat (3) @(negedge Clock);
        Resetn = 1'b0;
        #1;
        check("abort_bcd8", 32'(Bcd8), 32'd0);
        check("abort_hex8", 32'(HEX8), 32'h1FFFFF);
        check("abort_busy8", 32'(Busy8), 32'd0);
        check("abort_done8", 32'(Done8), 32'd0);
        d0 = done8_cnt;
        repeat (3) @(negedge Clock);
        Resetn = 1'b1;
        repeat (15) @(negedge Clock);
        check("abort_no_done", 32'(done8_cnt - d0), 32'd0);
        conv8(199);

        for (int i = 0; i < 25; i++) conv8(int'($urandom_range(0, 255)));
        for (int v = 0; v < 16; v++) conv4(v);

        repeat (5) @(negedge Clock);
        check("q8_drained", 32'(q8.size()), 32'd0);
        check("q8n_drained", 32'(q8n.size()), 32'd0);
        check("q4_drained", 32'(q4.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
